// File: rtl/shot_fire_control.sv
// Fire-key front end for the shot stock manager: debounce, aim latch, ammo, cooldown and reload.
// Optional build macro SHOT_FIRE_AUTOREPEAT_EN: a held key re-fires at the end of each cooldown.
module shot_fire_control #(
  parameter int DEBOUNCE_FRAMES    = 2,
  parameter int COOLDOWN_FRAMES    = 8,
  parameter int RELOAD_FRAMES      = 60,
  parameter int MAX_AMMO           = 9,
  parameter int REQ_TIMEOUT_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       pause,
  input  logic       fireKey,
  input  logic       aimLeft,
  input  logic       aimRight,
  input  logic       poweredUp,
  input  logic       shot_fired,
  input  logic       nonAvailable,
  output logic       trigger,
  output logic [2:0] shotDirection,
  output logic [3:0] ammo,
  output logic       reloading,
  output logic       emptyClick,
  output logic [1:0] fsm_state
);

  localparam int DW = (DEBOUNCE_FRAMES > 0)    ? $clog2(DEBOUNCE_FRAMES + 1)    : 1;
  localparam int CW = (COOLDOWN_FRAMES > 0)    ? $clog2(COOLDOWN_FRAMES + 1)    : 1;
  localparam int LW = (RELOAD_FRAMES > 0)      ? $clog2(RELOAD_FRAMES + 1)      : 1;
  localparam int RW = (REQ_TIMEOUT_FRAMES > 0) ? $clog2(REQ_TIMEOUT_FRAMES + 1) : 1;

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DEB_PRE  = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [LW-1:0] RL_LAST  = LW'(RELOAD_FRAMES - 1);
  localparam logic [RW-1:0] REQ_LAST = RW'(REQ_TIMEOUT_FRAMES - 1);
  localparam logic [3:0]    AMMO_MAX = 4'(MAX_AMMO);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_COOLDOWN = 2'd2,
    S_RELOAD   = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] deb_cnt;
  logic [CW-1:0] cd_cnt;
  logic [LW-1:0] rl_cnt;
  logic [RW-1:0] req_cnt;
  logic [2:0]    aim_dir;
  logic [CW-1:0] cd_limit;
  logic          press;

  assign fsm_state = state;

  // press fires in the startOfFrame cycle in which the debounce counter reaches
  // its limit, so the request is registered on that same edge.
  assign press    = startOfFrame && fireKey && (deb_cnt == DEB_PRE);
  assign cd_limit = poweredUp ? CW'(COOLDOWN_FRAMES >> 1) : CW'(COOLDOWN_FRAMES);

`ifdef SHOT_FIRE_AUTOREPEAT_EN
  logic key_down;
  assign key_down = (deb_cnt == DEB_MAX);
`endif

  always_comb begin
    aim_dir = 3'b010;
    if (aimLeft && !aimRight)      aim_dir = 3'b001;
    else if (aimRight && !aimLeft) aim_dir = 3'b100;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
    end else if (startOfFrame) begin
      if (!fireKey)                deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Handshake: trigger is a level held from entry into REQ until the stock
  // manager answers with a 1-cycle shot_fired or nonAvailable (shot_fired wins),
  // or the request is abandoned on pause or timeout; it drops on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      trigger       <= 1'b0;
      shotDirection <= 3'b010;
      ammo          <= AMMO_MAX;
      reloading     <= 1'b0;
      emptyClick    <= 1'b0;
      cd_cnt        <= '0;
      rl_cnt        <= '0;
      req_cnt       <= '0;
    end else begin
      emptyClick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press && !pause) begin
            state         <= S_REQ;
            trigger       <= 1'b1;
            shotDirection <= aim_dir;
            req_cnt       <= '0;
          end
        end

        S_REQ: begin
          if (shot_fired) begin
            trigger <= 1'b0;
            ammo    <= (ammo != 4'd0) ? ammo - 4'd1 : 4'd0;
            if (ammo <= 4'd1) begin
              state     <= S_RELOAD;
              reloading <= 1'b1;
              rl_cnt    <= '0;
            end else begin
              state  <= S_COOLDOWN;
              cd_cnt <= cd_limit;
            end
          end else if (nonAvailable) begin
            state      <= S_IDLE;
            trigger    <= 1'b0;
            emptyClick <= 1'b1;
          end else if (pause) begin
            state   <= S_IDLE;
            trigger <= 1'b0;
          end else if (startOfFrame) begin
            if (req_cnt == REQ_LAST) begin
              state   <= S_IDLE;
              trigger <= 1'b0;
            end else begin
              req_cnt <= req_cnt + 1'b1;
            end
          end
        end

        S_COOLDOWN: begin
          if (!pause) begin
            if (cd_cnt == '0 || (startOfFrame && cd_cnt == CW'(1))) begin
              cd_cnt <= '0;
              state  <= S_IDLE;
`ifdef SHOT_FIRE_AUTOREPEAT_EN
              if (key_down && ammo != 4'd0) begin
                state         <= S_REQ;
                trigger       <= 1'b1;
                shotDirection <= aim_dir;
                req_cnt       <= '0;
              end
`endif
            end else if (startOfFrame) begin
              cd_cnt <= cd_cnt - 1'b1;
            end
          end
        end

        S_RELOAD: begin
          if (press) emptyClick <= 1'b1;
          if (!pause && startOfFrame) begin
            if (rl_cnt == RL_LAST) begin
              state     <= S_IDLE;
              reloading <= 1'b0;
              ammo      <= AMMO_MAX;
              rl_cnt    <= '0;
            end else begin
              rl_cnt <= rl_cnt + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
